// File: rtl/exmem_data_stage_if.sv
// EX-to-MEM bus of the MIPS pipeline: values leaving execute and the MEM-stage results
// handed to forwarding and write-back.
interface exmem_data_stage_if;
    logic [31:0] Instr_E;
    logic [31:0] PC_plus_8_E;
    logic [31:0] ALUResult_E;
    logic [31:0] rt_value_E;
    logic [4:0]  WriteRegNum_E;
    logic        Link_E;
    logic [31:0] Instr_M;
    logic [31:0] ALUResult_M;
    logic [31:0] jal_pc_from_M;
    logic [4:0]  WriteRegNum_M;
    logic        RegWrite_M;
    logic [31:0] ReadData_M;
    logic        MemErr_M;

    modport master (
        output Instr_E, PC_plus_8_E, ALUResult_E, rt_value_E, WriteRegNum_E, Link_E,
        input  Instr_M, ALUResult_M, jal_pc_from_M, WriteRegNum_M, RegWrite_M,
               ReadData_M, MemErr_M
    );

    modport slave (
        input  Instr_E, PC_plus_8_E, ALUResult_E, rt_value_E, WriteRegNum_E, Link_E,
        output Instr_M, ALUResult_M, jal_pc_from_M, WriteRegNum_M, RegWrite_M,
               ReadData_M, MemErr_M
    );
endinterface

// File: rtl/exmem_data_stage.sv
// MEM stage: EX/MEM pipeline register, word-addressed data memory for lw/sw and the
// register-write decode consumed by write-back and forwarding.
module exmem_data_stage #(
    parameter int          DM_DEPTH = 1024,
    parameter logic [31:0] DM_BASE  = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    exmem_data_stage_if.slave bus
);
    localparam int          AW       = $clog2(DM_DEPTH);
    localparam logic [31:0] DM_BYTES = 32'(4 * DM_DEPTH);

    localparam logic [5:0] OP_RTYPE   = 6'b000000;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_LUI     = 6'b001111;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_SW      = 6'b101011;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BLEZALS = 6'b011000;
    localparam logic [5:0] FN_ADDU    = 6'b100001;
    localparam logic [5:0] FN_SUBU    = 6'b100011;

    logic [31:0] instr_r;
    logic [31:0] alu_r;
    logic [31:0] pc8_r;
    logic [31:0] rt_r;
    logic [4:0]  wreg_r;
    logic        link_r;
    logic [31:0] dm_r [DM_DEPTH];

    logic [5:0]    op_s;
    logic [5:0]    funct_s;
    logic [31:0]   off_s;
    logic [AW-1:0] idx_s;
    logic          addr_ok_s;
    logic          is_lw_s;
    logic          is_sw_s;
    logic          regwrite_s;
    logic [4:0]    wreg_out_s;
    logic [31:0]   read_data_s;
    logic          mem_err_s;

    // Pipeline register and memory; the store retires on the edge that ends its MEM cycle,
    // so a back-to-back lw to the same word sees the new data. Reset discards the store.
    always_ff @(posedge clk) begin
        if (!reset) begin
            instr_r <= 32'd0;
            alu_r   <= 32'd0;
            pc8_r   <= 32'd0;
            rt_r    <= 32'd0;
            wreg_r  <= 5'd0;
            link_r  <= 1'b0;
            for (int i = 0; i < DM_DEPTH; i++) begin
                dm_r[i] <= 32'd0;
            end
        end else begin
            if (is_sw_s && addr_ok_s) begin
                dm_r[idx_s] <= rt_r;
            end
            instr_r <= bus.Instr_E;
            alu_r   <= bus.ALUResult_E;
            pc8_r   <= bus.PC_plus_8_E;
            rt_r    <= bus.rt_value_E;
            wreg_r  <= bus.WriteRegNum_E;
            link_r  <= bus.Link_E;
        end
    end

    // Address check, register-write decode and load data for the instruction in MEM.
    always_comb begin
        op_s      = instr_r[31:26];
        funct_s   = instr_r[5:0];
        off_s     = alu_r - DM_BASE;
        idx_s     = off_s[AW+1:2];
        addr_ok_s = (off_s[1:0] == 2'b00) && (off_s < DM_BYTES);
        is_lw_s   = (op_s == OP_LW);
        is_sw_s   = (op_s == OP_SW);
        case (op_s)
            OP_RTYPE: begin
                if ((funct_s == FN_ADDU) || (funct_s == FN_SUBU)) begin
                    regwrite_s = 1'b1;
                end else begin
                    regwrite_s = 1'b0;
                end
            end
            OP_ORI, OP_LUI, OP_LW, OP_JAL: regwrite_s = 1'b1;
            OP_BLEZALS:                    regwrite_s = link_r;
            default:                       regwrite_s = 1'b0;
        endcase
        if (regwrite_s) begin
            wreg_out_s = wreg_r;
        end else begin
            wreg_out_s = 5'd0;
        end
        if (is_lw_s && addr_ok_s) begin
            read_data_s = dm_r[idx_s];
        end else begin
            read_data_s = 32'd0;
        end
        mem_err_s = (is_lw_s || is_sw_s) && !addr_ok_s;
    end

    assign bus.Instr_M       = instr_r;
    assign bus.ALUResult_M   = alu_r;
    assign bus.jal_pc_from_M = pc8_r;
    assign bus.WriteRegNum_M = wreg_out_s;
    assign bus.RegWrite_M    = regwrite_s;
    assign bus.ReadData_M    = read_data_s;
    assign bus.MemErr_M      = mem_err_s;
endmodule

// File: tb/tb_exmem_data_stage.sv
// Directed bench for exmem_data_stage: hand-computed expectations for reset, memory
// access, address errors and the register-write decode.
module tb_exmem_data_stage;
    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    localparam logic [31:0] NOP     = 32'h0000_0000;
    localparam logic [31:0] LW      = 32'h8C00_0000;
    localparam logic [31:0] SW      = 32'hAC00_0000;
    localparam logic [31:0] JAL     = 32'h0C00_0000;
    localparam logic [31:0] BLEZALS = 32'h6000_0000;
    localparam logic [31:0] BEQ     = 32'h1000_0000;
    localparam logic [31:0] ORI     = 32'h3400_0000;
    localparam logic [31:0] LUI     = 32'h3C00_0000;
    localparam logic [31:0] ADDU    = 32'h0000_0021;
    localparam logic [31:0] SUBU    = 32'h0000_0023;
    localparam logic [31:0] JR      = 32'h0000_0008;
    localparam logic [31:0] BADOP   = 32'hFC00_0000;

    exmem_data_stage_if bus ();

    exmem_data_stage #(.DM_DEPTH(1024), .DM_BASE(32'h0000_0000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] instr, input logic [31:0] alu,
                         input logic [31:0] rt, input logic [31:0] pc8,
                         input logic [4:0] wr, input logic link);
        bus.Instr_E       = instr;
        bus.ALUResult_E   = alu;
        bus.rt_value_E    = rt;
        bus.PC_plus_8_E   = pc8;
        bus.WriteRegNum_E = wr;
        bus.Link_E        = link;
        tick();
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".instr"}, bus.Instr_M, 32'd0);
        check({tag, ".alu"},   bus.ALUResult_M, 32'd0);
        check({tag, ".pc8"},   bus.jal_pc_from_M, 32'd0);
        check({tag, ".wreg"},  {27'd0, bus.WriteRegNum_M}, 32'd0);
        check({tag, ".rw"},    {31'd0, bus.RegWrite_M}, 32'd0);
        check({tag, ".rd"},    bus.ReadData_M, 32'd0);
        check({tag, ".err"},   {31'd0, bus.MemErr_M}, 32'd0);
    endtask

    task automatic lw_expect(input string tag, input logic [31:0] addr,
                             input logic [31:0] exp_data, input logic exp_err);
        issue(LW, addr, 32'd0, 32'd0, 5'd9, 1'b0);
        check({tag, ".rd"},  bus.ReadData_M, exp_data);
        check({tag, ".err"}, {31'd0, bus.MemErr_M}, {31'd0, exp_err});
    endtask

    task automatic rw_expect(input string tag, input logic [31:0] instr, input logic [4:0] wr,
                             input logic link, input logic exp_rw, input logic [4:0] exp_wr);
        issue(instr, 32'h0000_0040, 32'd0, 32'h0000_1008, wr, link);
        check({tag, ".rw"},   {31'd0, bus.RegWrite_M}, {31'd0, exp_rw});
        check({tag, ".wreg"}, {27'd0, bus.WriteRegNum_M}, {27'd0, exp_wr});
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b0;
        bus.Instr_E = NOP;  bus.ALUResult_E = 32'h1234_5678;  bus.rt_value_E = 32'hFFFF_FFFF;
        bus.PC_plus_8_E = 32'h0000_0100;  bus.WriteRegNum_E = 5'd7;  bus.Link_E = 1'b1;

        // Reset held two cycles: everything reads zero even with busy inputs.
        tick();
        tick();
        check_idle("rst");
        reset = 1'b1;
        issue(NOP, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0);
        for (int a = 0; a < 4; a++) begin
            lw_expect($sformatf("rst_dm%0d", a), 32'(a * 4), 32'd0, 1'b0);
        end

        // Store then immediate load of the same word.
        issue(SW, 32'h0000_0010, 32'hDEAD_BEEF, 32'd0, 5'd5, 1'b0);
        check("sw.rw",   {31'd0, bus.RegWrite_M}, 32'd0);
        check("sw.wreg", {27'd0, bus.WriteRegNum_M}, 32'd0);
        check("sw.err",  {31'd0, bus.MemErr_M}, 32'd0);
        check("sw.rd",   bus.ReadData_M, 32'd0);
        issue(LW, 32'h0000_0010, 32'd0, 32'd0, 5'd8, 1'b0);
        check("lw.rd",   bus.ReadData_M, 32'hDEAD_BEEF);
        check("lw.rw",   {31'd0, bus.RegWrite_M}, 32'd1);
        check("lw.wreg", {27'd0, bus.WriteRegNum_M}, 32'd8);

        // Misaligned and out-of-range stores are flagged and dropped.
        issue(SW, 32'h0000_0012, 32'h1111_1111, 32'd0, 5'd0, 1'b0);
        check("sw_mis.err", {31'd0, bus.MemErr_M}, 32'd1);
        issue(SW, 32'h0000_1000, 32'h2222_2222, 32'd0, 5'd0, 1'b0);
        check("sw_oor.err", {31'd0, bus.MemErr_M}, 32'd1);
        issue(SW, 32'h0000_0FFC, 32'hCAFE_F00D, 32'd0, 5'd0, 1'b0);
        check("sw_top.err", {31'd0, bus.MemErr_M}, 32'd0);
        lw_expect("lw_keep10", 32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
        lw_expect("lw_keep0",  32'h0000_0000, 32'd0, 1'b0);
        lw_expect("lw_mis",    32'h0000_0012, 32'd0, 1'b1);
        lw_expect("lw_oor",    32'h0000_1000, 32'd0, 1'b1);
        lw_expect("lw_top",    32'h0000_0FFC, 32'hCAFE_F00D, 1'b0);
        lw_expect("lw_wrap",   32'hFFFF_FFFC, 32'd0, 1'b1);

        // jal link value and destination.
        issue(JAL, 32'h0000_0044, 32'd0, 32'h0000_3008, 5'd31, 1'b0);
        check("jal.pc8",  bus.jal_pc_from_M, 32'h0000_3008);
        check("jal.alu",  bus.ALUResult_M, 32'h0000_0044);
        check("jal.wreg", {27'd0, bus.WriteRegNum_M}, 32'd31);
        check("jal.rw",   {31'd0, bus.RegWrite_M}, 32'd1);
        check("jal.rd",   bus.ReadData_M, 32'd0);

        // Register-write decode across the instruction set.
        rw_expect("blezals0", BLEZALS, 5'd31, 1'b0, 1'b0, 5'd0);
        rw_expect("blezals1", BLEZALS, 5'd31, 1'b1, 1'b1, 5'd31);
        rw_expect("addu_r0",  ADDU,    5'd0,  1'b0, 1'b1, 5'd0);
        rw_expect("subu",     SUBU,    5'd3,  1'b0, 1'b1, 5'd3);
        rw_expect("ori",      ORI,     5'd4,  1'b0, 1'b1, 5'd4);
        rw_expect("lui",      LUI,     5'd6,  1'b1, 1'b1, 5'd6);
        rw_expect("beq",      BEQ,     5'd2,  1'b1, 1'b0, 5'd0);
        rw_expect("jr",       JR,      5'd31, 1'b1, 1'b0, 5'd0);
        rw_expect("nop",      NOP,     5'd10, 1'b1, 1'b0, 5'd0);
        rw_expect("badop",    BADOP,   5'd11, 1'b1, 1'b0, 5'd0);
        check("badop.err", {31'd0, bus.MemErr_M}, 32'd0);

        // Reset on the edge that would retire a store: store lost, memory cleared.
        issue(SW, 32'h0000_0020, 32'h0000_0055, 32'd0, 5'd0, 1'b0);
        reset = 1'b0;
        issue(NOP, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0);
        check_idle("rst_sw");
        reset = 1'b1;
        lw_expect("rst_sw20", 32'h0000_0020, 32'd0, 1'b0);
        lw_expect("rst_sw10", 32'h0000_0010, 32'd0, 1'b0);
        lw_expect("rst_swFFC", 32'h0000_0FFC, 32'd0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
